score_display: RTL
==================

Name: score_display

Overview:
- Parametrised successor to the game's hard-wired seven-segment path, which uses fixed per-digit hex drivers plus hand-wired sign and hundreds segments.
- Takes a binary score or value (unsigned or two's-complement) on a load strobe and converts it to decimal serially (double-dabble, one bit per cycle).
- Formats the result across NUM_DIGITS active-low seven-segment digits, with leading-zero blanking, a minus sign, overflow dashes and optional blinking.
- Sits between the game logic (score, lives, timer) and the board's HEX outputs.

Parameters:
- NUM_DIGITS, 6, number of displayed digits (1..8).
- BIN_WIDTH, 20, width of the input value (4..27).
- BLINK_DIV, 12_500_000, Clk cycles per blink half-period (>=2).

Ports:
- Clk  input  1  system clock.
- Reset  input  1  synchronous, active-high reset.
- value  input  BIN_WIDTH  value to display; sampled only on an accepted load.
- signed_mode  input  1  1 = treat value as two's-complement; sampled with value.
- load  input  1  single-cycle request; accepted only when busy=0.
- blink_en  input  1  level; enables blanking of the whole display on alternate half-periods.
- busy  output  1  conversion in progress; load is ignored while high.
- done  output  1  one-cycle pulse, asserted in the same cycle new seg data first appears.
- overflow  output  1  registered; set when the last accepted value did not fit.
- seg  output  NUM_DIGITS*8  digit i occupies bits [8i+7:8i]; digit 0 is rightmost; within a digit bit7=dp, bits[6:0]=gfedcba; active-low.

Behaviour:
- Reset (synchronous, highest priority):
  - state=IDLE, busy=0, done=0, overflow=0.
  - seg all 8'hFF (blank).
  - Blink counter=0, blink phase=on.
- Reset mid-conversion aborts the conversion; seg returns to blank and no done pulse is issued.
- States:
  - IDLE: load=1 captures the operand, sign and mode; next state CONV; busy=1 from the next cycle.
  - CONV: runs exactly BIN_WIDTH cycles. Each cycle adds 3 to every BCD nibble >=5, then shifts the magnitude MSB into the BCD register. A bit counter ends the state; next state FMT.
  - FMT: one cycle; builds the seg image; next state IDLE.
- Latency: load sampled at edge k; seg, overflow and done update at edge k+BIN_WIDTH+2; busy falls at the same edge.
- A load arriving in the same cycle as done is accepted.
- Operand capture:
  - Magnitude = value, or its two's-complement when signed_mode=1 and value MSB=1.
  - Magnitude is held in BIN_WIDTH+1 bits so that the most-negative value is correct.
  - neg = signed_mode & value MSB.
- The BCD register has enough nibbles for the full magnitude: ceil((BIN_WIDTH+1)*0.302)+1.
- Formatting:
  - Leading zeros are blanked (8'hFF). Digit 0 always shows a numeral, so zero displays as 8'hC0.
  - Numeral codes 0..9: C0,F9,A4,B0,99,92,82,F8,80,90. dp is always off.
  - When neg=1, minus (8'hBF) goes in the digit immediately left of the most significant numeral.
- Overflow condition:
  - Unsigned or positive: magnitude >= 10^NUM_DIGITS.
  - Negative: magnitude >= 10^(NUM_DIGITS-1).
  - On overflow every digit = 8'hBF and overflow=1; otherwise overflow=0.
  - The limits are elaboration-time constants.
- Blink:
  - The counter runs continuously from 0 to BLINK_DIV-1 and toggles the phase on wrap.
  - When blink_en=1 and phase=off, seg is forced to all 8'hFF; the stored image is kept.
  - When blink_en=0, the displayed seg is the stored image; the counter keeps running.
  - Blinking does not affect busy, done or overflow.
- seg is fully registered (no combinational path from inputs).

Decomposition:
- Package score_display_pkg:
  - state enum {IDLE, CONV, FMT}.
  - SEG_BLANK=8'hFF, SEG_MINUS=8'hBF.
  - Numeral lookup table.
  - Function computing 10^n.
  - Function computing the BCD nibble count.
- Sub-module bcd7seg: combinational nibble-to-active-low-segment decode, instantiated per digit during FMT.

Test Plan (NUM_DIGITS=6, BIN_WIDTH=20 unless noted):
- Reset, no load: seg=48'hFFFF_FFFF_FFFF, busy=0, done=0, overflow=0.
- Load value=1234, signed_mode=0 at edge k: done at k+22; seg=FF,FF,F9,A4,B0,99 (digits 5..0); overflow=0. Then value=0: seg=FF..FF,C0.
- value=20'hFFB2E (-1234), signed_mode=1: seg=FF,BF,F9,A4,B0,99. value=20'h80000 (-524288): all BF, overflow=1. Also 999999 unsigned -> 90 in every digit; 1000000 -> all BF, overflow=1.
- Load 42, then a second load of 77 two cycles later while busy=1: the second load is ignored; one done pulse; seg shows 42 (digits 1..0 = 99,A4). A load on the done cycle is accepted.
- Reset asserted at CONV cycle 10: next cycle state=IDLE, busy=0, seg all FF; no done pulse follows.
- BLINK_DIV=4, blink_en=1 after 42 is displayed: seg alternates between the 42 image and all FF every 4 cycles. Dropping blink_en restores the image on the next cycle.

Source files
------------

// File: rtl/score_display_pkg.sv
// Shared types, segment constants and elaboration-time helpers for score_display.
package score_display_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        FMT
    } state_t;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] SEG_MINUS = 8'hBF;

    // Active-low gfedcba codes for numerals 0..9, dp off.
    localparam logic [7:0] SEG_LUT [10] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
        8'h92, 8'h82, 8'hF8, 8'h80, 8'h90
    };

    function automatic logic [63:0] pow10(input int unsigned n);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            p = p * 64'd10;
        end
        return p;
    endfunction

    // ceil((bw+1)*0.302)+1 nibbles hold any bw+1 bit magnitude with one spare.
    function automatic int unsigned bcd_nibbles(input int unsigned bw);
        return ((bw + 1) * 302 + 999) / 1000 + 1;
    endfunction

endpackage

// File: rtl/score_display_bcd7seg.sv
// Combinational BCD nibble to active-low seven-segment decode.
module bcd7seg
    import score_display_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [7:0] o_seg
);

    // Non-decimal nibbles never reach a displayed digit; decode them as blank.
    always_comb begin
        o_seg = SEG_BLANK;
        if (i_nib <= 4'd9) begin
            o_seg = SEG_LUT[i_nib];
        end
    end

endmodule

// File: rtl/score_display.sv
// Serial binary-to-decimal converter driving NUM_DIGITS active-low
// seven-segment digits with blanking, sign, overflow dashes and blink.
module score_display
    import score_display_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned BIN_WIDTH  = 20,
    parameter int unsigned BLINK_DIV  = 12_500_000
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic [BIN_WIDTH-1:0]      value,
    input  logic                      signed_mode,
    input  logic                      load,
    input  logic                      blink_en,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic [NUM_DIGITS*8-1:0]   seg
);

    localparam int unsigned NBCD   = bcd_nibbles(BIN_WIDTH);
    localparam int unsigned NSTORE = (NBCD > NUM_DIGITS) ? NBCD : NUM_DIGITS;
    localparam int unsigned BCD_W  = 4 * NSTORE;
    localparam int unsigned SEG_W  = 8 * NUM_DIGITS;
    localparam int unsigned BITC_W = $clog2(BIN_WIDTH + 1);
    localparam int unsigned CNT_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [63:0]        LIM_POS   = pow10(NUM_DIGITS);
    localparam logic [63:0]        LIM_NEG   = pow10(NUM_DIGITS - 1);
    localparam logic [SEG_W-1:0]   ALL_BLANK = {NUM_DIGITS{SEG_BLANK}};
    localparam logic [SEG_W-1:0]   ALL_MINUS = {NUM_DIGITS{SEG_MINUS}};

    state_t              r_state;
    logic                r_busy;
    logic                r_done;
    logic                r_ovf_out;
    logic [SEG_W-1:0]    r_seg;
    logic [SEG_W-1:0]    r_image;
    logic [SEG_W-1:0]    r_fmt_img;
    logic                r_fmt_ovf;
    logic                r_pub;
    logic [BCD_W-1:0]    r_bcd;
    logic [BIN_WIDTH-1:0] r_mag;
    logic [BITC_W-1:0]   r_bit;
    logic                r_neg;
    logic                r_ovf;
    logic [CNT_W-1:0]    r_blink_cnt;
    logic                r_phase_on;

    logic                w_neg;
    logic [BIN_WIDTH:0]  w_mag;
    logic                w_ovf;
    logic [BCD_W-1:0]    w_adj;
    logic [3:0]          w_nib [NUM_DIGITS];
    logic [7:0]          w_dec [NUM_DIGITS];
    logic [3:0]          w_msd;
    logic [SEG_W-1:0]    w_img;
    logic [SEG_W-1:0]    w_next_img;

    assign busy     = r_busy;
    assign done     = r_done;
    assign overflow = r_ovf_out;
    assign seg      = r_seg;

    // Operand capture: magnitude is one bit wider so the most-negative value negates cleanly.
    always_comb begin
        w_neg = signed_mode & value[BIN_WIDTH-1];
        w_mag = {1'b0, value};
        if (w_neg) begin
            w_mag = ~{value[BIN_WIDTH-1], value} + {{BIN_WIDTH{1'b0}}, 1'b1};
        end
        w_ovf = w_neg ? (64'(w_mag) >= LIM_NEG) : (64'(w_mag) >= LIM_POS);
    end

    // Double-dabble correction: add 3 to every nibble that is 5 or more.
    always_comb begin
        w_adj = r_bcd;
        for (int unsigned i = 0; i < NSTORE; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Locate the most significant non-zero displayed nibble (digit 0 if all zero).
    always_comb begin
        w_msd = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            w_nib[i] = r_bcd[4*i +: 4];
            if (r_bcd[4*i +: 4] != 4'd0) begin
                w_msd = 4'(i);
            end
        end
    end

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
        bcd7seg u_dec (
            .i_nib (w_nib[g]),
            .o_seg (w_dec[g])
        );
    end

    // Build the display image: numerals up to the MSD, minus just left of it, blanks above.
    always_comb begin
        w_img = ALL_BLANK;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (r_ovf) begin
                w_img[8*i +: 8] = SEG_MINUS;
            end else if (4'(i) <= w_msd) begin
                w_img[8*i +: 8] = w_dec[i];
            end else if (r_neg && (4'(i) == w_msd + 4'd1)) begin
                w_img[8*i +: 8] = SEG_MINUS;
            end
        end
    end

    // The image shown next cycle: a freshly formatted one on publish, else the stored one.
    always_comb begin
        w_next_img = r_pub ? r_fmt_img : r_image;
    end

    // Free-running blink half-period counter.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_blink_cnt <= '0;
            r_phase_on  <= 1'b1;
        end else if (r_blink_cnt == CNT_W'(BLINK_DIV - 1)) begin
            r_blink_cnt <= '0;
            r_phase_on  <= ~r_phase_on;
        end else begin
            r_blink_cnt <= r_blink_cnt + 1'b1;
        end
    end

    // Control FSM plus registered outputs; publishing happens one edge after FMT.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_ovf_out <= 1'b0;
            r_seg     <= ALL_BLANK;
            r_image   <= ALL_BLANK;
            r_fmt_img <= ALL_BLANK;
            r_fmt_ovf <= 1'b0;
            r_pub     <= 1'b0;
            r_bcd     <= '0;
            r_mag     <= '0;
            r_bit     <= '0;
            r_neg     <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_seg  <= (blink_en && !r_phase_on) ? ALL_BLANK : w_next_img;

            case (r_state)
                IDLE: begin
                    if (load && !r_busy) begin
                        // Magnitude never exceeds 2^BIN_WIDTH-1, so its top bit is dropped here.
                        r_mag   <= w_mag[BIN_WIDTH-1:0];
                        r_neg   <= w_neg;
                        r_ovf   <= w_ovf;
                        r_bcd   <= '0;
                        r_bit   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= CONV;
                    end
                end
                CONV: begin
                    r_bcd <= (w_adj << 1) | BCD_W'(r_mag[BIN_WIDTH-1]);
                    r_mag <= r_mag << 1;
                    r_bit <= r_bit + 1'b1;
                    if (r_bit == BITC_W'(BIN_WIDTH - 1)) begin
                        r_state <= FMT;
                    end
                end
                FMT: begin
                    r_fmt_img <= w_img;
                    r_fmt_ovf <= r_ovf;
                    r_pub     <= 1'b1;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase

            if (r_pub) begin
                r_pub     <= 1'b0;
                r_image   <= r_fmt_img;
                r_ovf_out <= r_fmt_ovf;
                r_done    <= 1'b1;
                r_busy    <= 1'b0;
            end
        end
    end

endmodule
